pp_mult_seq_ctrl: RTL and testbench

//  Sequencer for the partial-product multiplier datapath. Accepts one operand

---
 rtl/pp_mult_pkg.sv | 17 +
 rtl/pp_mult_seq_ctrl_pp_row_gen.sv | 17 +
 rtl/pp_mult_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_pp_mult_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_mult_pkg.sv
// Shared types and helpers for the sequential partial-product multiplier.
package pp_mult_pkg;

    localparam int unsigned PP_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width that never collapses to zero bits for tiny operands.
    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_mult_seq_ctrl_pp_row_gen.sv
// Combinational partial-product row: extended multiplicand gated by one multiplier bit, shifted.
module pp_row_gen
    import pp_mult_pkg::*;
#(
    parameter int unsigned WIDTH = PP_WIDTH_DEFAULT
) (
    input  logic [2*WIDTH-1:0]            a_ext,
    input  logic                          b_bit,
    input  logic [clog2_safe(WIDTH)-1:0]  shift,
    output logic [2*WIDTH-1:0]            row
);

    localparam int unsigned PW = 2 * WIDTH;

    assign row = (a_ext & {PW{b_bit}}) << shift;

endmodule

// File: rtl/pp_mult_seq_ctrl.sv
// Sequential multiplier: one partial-product row per cycle into a 2*WIDTH accumulator,
// result returned over valid/ready.
module pp_mult_seq_ctrl
    import pp_mult_pkg::*;
#(
    parameter int unsigned WIDTH  = PP_WIDTH_DEFAULT,
    parameter int unsigned SIGNED = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    input  logic                          abort,
    output logic                          busy,
    output logic [clog2_safe(WIDTH)-1:0]  row_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WIDTH-1:0]            product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned IW = clog2_safe(WIDTH);

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d, product_q, product_d;
    logic [IW-1:0]   row_idx_q, row_idx_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   row;
    logic            last_row;

    assign a_ext    = (SIGNED != 0) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign last_row = (row_idx_q == IW'(WIDTH - 1));

    pp_row_gen #(.WIDTH(WIDTH)) u_row_gen (
        .a_ext (a_ext),
        .b_bit (b_q[row_idx_q]),
        .shift (row_idx_q),
        .row   (row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            row_idx_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            row_idx_q   <= row_idx_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        product_d   = product_q;
        row_idx_d   = row_idx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    acc_d     = '0;
                    row_idx_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    // The sign bit of a two's-complement multiplier carries negative weight.
                    if ((SIGNED != 0) && last_row) begin
                        acc_d = acc_q - row;
                    end else begin
                        acc_d = acc_q + row;
                    end
                    row_idx_d = row_idx_q + IW'(1);
                    if (last_row) begin
                        state_d     = DONE;
                        product_d   = acc_d;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (state_d != RUN) begin
            row_idx_d = '0;
        end
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign row_idx   = row_idx_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_pp_mult_seq_ctrl.sv
// Directed and random checks of pp_mult_seq_ctrl at WIDTH=5, signed and unsigned builds.
module tb_pp_mult_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sel;
    logic       drv_in_valid, drv_abort, op_ready;
    logic [4:0] op_a, op_b;

    logic       sg_in_valid, sg_in_ready, sg_abort, sg_busy, sg_out_valid;
    logic [2:0] sg_row_idx;
    logic [9:0] sg_product;
    logic       us_in_valid, us_in_ready, us_abort, us_busy, us_out_valid;
    logic [2:0] us_row_idx;
    logic [9:0] us_product;

    logic       o_in_ready, o_busy, o_out_valid;
    logic [2:0] o_row_idx;
    logic [9:0] o_product;

    int n_checks = 0;
    int n_fail   = 0;

    assign sg_in_valid = sel & drv_in_valid;
    assign us_in_valid = ~sel & drv_in_valid;
    assign sg_abort    = sel & drv_abort;
    assign us_abort    = ~sel & drv_abort;

    assign o_in_ready  = sel ? sg_in_ready  : us_in_ready;
    assign o_busy      = sel ? sg_busy      : us_busy;
    assign o_out_valid = sel ? sg_out_valid : us_out_valid;
    assign o_row_idx   = sel ? sg_row_idx   : us_row_idx;
    assign o_product   = sel ? sg_product   : us_product;

    pp_mult_seq_ctrl #(.WIDTH(5), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(sg_in_valid), .in_ready(sg_in_ready),
        .a(op_a), .b(op_b), .abort(sg_abort), .busy(sg_busy), .row_idx(sg_row_idx),
        .out_valid(sg_out_valid), .out_ready(op_ready), .product(sg_product)
    );

    pp_mult_seq_ctrl #(.WIDTH(5), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(us_in_valid), .in_ready(us_in_ready),
        .a(op_a), .b(op_b), .abort(us_abort), .busy(us_busy), .row_idx(us_row_idx),
        .out_valid(us_out_valid), .out_ready(op_ready), .product(us_product)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits for out_valid; leaves the block in DONE.
    task automatic run_op(input logic s, input logic [4:0] a, input logic [4:0] b,
                          input bit rnd_ready, output logic [9:0] prod, output int lat);
        sel          = s;
        op_a         = a;
        op_b         = b;
        drv_in_valid = 1'b1;
        tick();
        drv_in_valid = 1'b0;
        op_a         = 5'($urandom);
        op_b         = 5'($urandom);
        lat          = 0;
        while (!o_out_valid && lat < 20) begin
            if (rnd_ready) op_ready = 1'($urandom);
            tick();
            lat++;
        end
        prod = o_product;
    endtask

    task automatic finish_op;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic s, input logic [4:0] a,
                            input logic [4:0] b, input logic [9:0] exp);
        logic [9:0] prod;
        int lat;
        run_op(s, a, b, 1'b0, prod, lat);
        n_checks++;
        if (prod !== exp) begin
            n_fail++;
            $display("FAIL %s product: got %h expected %h", name, prod, exp);
        end
        n_checks++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 5", name, lat);
        end
        finish_op();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 0);
            n_checks++;
            if ({o_in_ready, o_busy, o_out_valid, o_row_idx, o_product} !== {3'b100, 3'd0, 10'd0}) begin
                n_fail++;
                $display("FAIL reset_%0d: got rdy=%b busy=%b ov=%b idx=%0d prod=%h expected 1 0 0 0 000",
                         i, o_in_ready, o_busy, o_out_valid, o_row_idx, o_product);
            end
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_signed;
        check_op("s_7x-3",    1'b1, 5'd7,      5'b11101, 10'h3EB);
        check_op("s_-16x-16", 1'b1, 5'b10000,  5'b10000, 10'h100);
        check_op("s_-16x15",  1'b1, 5'b10000,  5'd15,    10'h310);
    endtask

    task automatic test_unsigned;
        check_op("u_31x31", 1'b0, 5'd31, 5'd31, 10'h3C1);
        check_op("u_0x31",  1'b0, 5'd0,  5'd31, 10'h000);
    endtask

    task automatic test_backpressure;
        logic [9:0] prod;
        int lat;
        run_op(1'b1, 5'd5, 5'd6, 1'b0, prod, lat);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (o_product !== 10'h01E || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got prod=%h rdy=%b ov=%b expected 01e 0 1",
                         i, o_product, o_in_ready, o_out_valid);
            end
        end
        drv_in_valid = 1'b1;
        op_ready     = 1'b1;
        tick();
        drv_in_valid = 1'b0;
        op_ready     = 1'b0;
        n_checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%b rdy=%b busy=%b expected 0 1 0",
                     o_out_valid, o_in_ready, o_busy);
        end
    endtask

    task automatic test_abort;
        logic [9:0] prev;
        bit seen_valid;
        prev         = o_product;
        sel          = 1'b1;
        op_a         = 5'd9;
        op_b         = 5'd11;
        drv_in_valid = 1'b1;
        tick();
        drv_in_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (o_row_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL abort_rowidx: got %0d expected 2", o_row_idx);
        end
        drv_abort = 1'b1;
        tick();
        drv_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_product !== prev) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b rdy=%b ov=%b prod=%h expected 0 1 0 %h",
                     o_busy, o_in_ready, o_out_valid, o_product, prev);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_out_valid) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid) begin
            n_fail++;
            $display("FAIL abort_no_valid: got out_valid=1 expected 0");
        end
        check_op("abort_next_3x3", 1'b1, 5'd3, 5'd3, 10'h009);
    endtask

    task automatic test_async_reset;
        sel          = 1'b1;
        op_a         = 5'd13;
        op_b         = 5'd7;
        drv_in_valid = 1'b1;
        tick();
        drv_in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_in_ready, o_busy, o_out_valid, o_row_idx, o_product} !== {3'b100, 3'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b busy=%b ov=%b idx=%0d prod=%h expected 1 0 0 0 000",
                     o_in_ready, o_busy, o_out_valid, o_row_idx, o_product);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random;
        logic [9:0] prod, exp;
        logic [4:0] ra, rb;
        logic       s;
        int lat, p, guard;
        for (int n = 0; n < 2000; n++) begin
            s  = 1'($urandom);
            ra = 5'($urandom);
            rb = 5'($urandom);
            p  = s ? int'($signed(ra)) * int'($signed(rb)) : int'(ra) * int'(rb);
            exp = 10'(p);
            op_ready = 1'b0;
            run_op(s, ra, rb, 1'b1, prod, lat);
            n_checks++;
            if (prod !== exp || lat != 5) begin
                n_fail++;
                $display("FAIL rand_%0d s=%b a=%h b=%h: got %h lat %0d expected %h lat 5",
                         n, s, ra, rb, prod, lat, exp);
            end
            guard = 0;
            while (o_out_valid && guard < 20) begin
                op_ready = (guard > 10) ? 1'b1 : 1'($urandom);
                tick();
                guard++;
            end
            op_ready = 1'b0;
        end
    endtask

    initial begin
        sel          = 1'b1;
        drv_in_valid = 1'b0;
        drv_abort    = 1'b0;
        op_ready     = 1'b0;
        op_a         = '0;
        op_b         = '0;
        test_reset();
        test_signed();
        test_unsigned();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
